// File: rtl/montgomery_multiplier_iter.sv
// Iterative radix-2 Montgomery multiplier: S = X*Y*2^-N mod M.
// Consumes BPC bits of X per clock with valid/ready handshakes on both sides.
// Build option: define MONT_FINAL_SUB_EN to add the final conditional
// subtraction (FIN state) so that S is fully reduced (0 <= S < M).
// Without it S is the raw accumulator (0 <= S < 2M, congruent mod M).
module montgomery_multiplier_iter #(
  parameter int N   = 16,
  parameter int BPC = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] X,
  input  logic [N-1:0] Y,
  input  logic [N-1:0] M,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N:0]   S,
  output logic         err,
  output logic         busy
);

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST_COUNT = CW'(N - BPC);
  localparam logic [CW-1:0] STEP_COUNT = CW'(BPC);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
`ifdef MONT_FINAL_SUB_EN
  localparam logic [1:0] FIN  = 2'd2;
`endif
  localparam logic [1:0] DONE = 2'd3;

  generate
    if ((N < 4) || ((N % BPC) != 0)) begin : g_param_check
      $error("montgomery_multiplier_iter: need N >= 4 and N %% BPC == 0");
    end
  endgenerate

`ifdef MONT_FINAL_SUB_EN
  // Reduce an accumulator known to be below 2M into [0, M).
  function automatic logic [N:0] final_sub(input logic [N+1:0] a, input logic [N-1:0] m);
    logic [N+1:0] mw;
    logic [N+1:0] d;
    mw = {2'b00, m};
    d  = a - mw;
    if (a >= mw) begin
      final_sub = d[N:0];
    end else begin
      final_sub = a[N:0];
    end
  endfunction
`endif

  logic [1:0]    state_r;
  logic [N+1:0]  acc_r;
  logic [CW-1:0] count_r;
  logic [N-1:0]  x_r;
  logic [N-1:0]  y_r;
  logic [N-1:0]  m_r;
  logic [N:0]    s_r;
  logic          err_r;
  logic          out_valid_r;
  logic          in_ready_r;
  logic          busy_r;
  logic [N+1:0]  acc_step_s;

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign S         = s_r;
  assign err       = err_r;
  assign busy      = busy_r;

  // BPC unrolled reduction steps on the low bits of the shifting X register.
  always_comb begin
    logic [N+2:0] sum_v;
    logic         q_v;
    sum_v      = {(N+3){1'b0}};
    q_v        = 1'b0;
    acc_step_s = acc_r;
    for (int k = 0; k < BPC; k++) begin
      q_v   = acc_step_s[0] ^ (x_r[k] & y_r[0]);
      sum_v = {1'b0, acc_step_s}
            + (x_r[k] ? {3'b000, y_r} : {(N+3){1'b0}})
            + (q_v    ? {3'b000, m_r} : {(N+3){1'b0}});
      acc_step_s = sum_v[N+2:1];
    end
  end

  // Control FSM, operand capture, accumulator and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= IDLE;
      acc_r       <= {(N+2){1'b0}};
      count_r     <= {CW{1'b0}};
      x_r         <= {N{1'b0}};
      y_r         <= {N{1'b0}};
      m_r         <= {N{1'b0}};
      s_r         <= {(N+1){1'b0}};
      err_r       <= 1'b0;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid && in_ready_r) begin
            x_r        <= X;
            y_r        <= Y;
            m_r        <= M;
            in_ready_r <= 1'b0;
            busy_r     <= 1'b1;
            if (!M[0]) begin
              // Even modulus: no Montgomery inverse exists, report at once.
              state_r     <= DONE;
              err_r       <= 1'b1;
              s_r         <= {(N+1){1'b0}};
              out_valid_r <= 1'b1;
            end else begin
              state_r <= RUN;
              err_r   <= 1'b0;
              acc_r   <= {(N+2){1'b0}};
              count_r <= {CW{1'b0}};
            end
          end
        end
        RUN: begin
          acc_r   <= acc_step_s;
          x_r     <= x_r >> BPC;
          count_r <= count_r + STEP_COUNT;
          if (count_r == LAST_COUNT) begin
`ifdef MONT_FINAL_SUB_EN
            state_r     <= FIN;
`else
            state_r     <= DONE;
            s_r         <= acc_step_s[N:0];
            out_valid_r <= 1'b1;
`endif
          end
        end
`ifdef MONT_FINAL_SUB_EN
        FIN: begin
          s_r         <= final_sub(acc_r, m_r);
          state_r     <= DONE;
          out_valid_r <= 1'b1;
        end
`endif
        DONE: begin
          if (out_ready) begin
            state_r     <= IDLE;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b0;
          end
        end
        default: begin
          state_r     <= IDLE;
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_montgomery_multiplier_iter.sv
// Self-checking bench for montgomery_multiplier_iter.
// Three instances: N=6/BPC=1 (a), N=6/BPC=2 (b), N=16/BPC=4 (c).
module tb_montgomery_multiplier_iter;

`ifdef MONT_FINAL_SUB_EN
  localparam int LAT_A = 8;
  localparam int LAT_B = 5;
  localparam int LAT_C = 6;
  localparam bit FULL_RED = 1'b1;
`else
  localparam int LAT_A = 7;
  localparam int LAT_B = 4;
  localparam int LAT_C = 5;
  localparam bit FULL_RED = 1'b0;
`endif

  typedef struct {
    logic [5:0] x;
    logic [5:0] y;
    logic [5:0] m;
    logic [6:0] s_on;
    logic [6:0] s_off;
    logic       e;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [5:0] x6, y6, m6;
  logic iv_a, ir_a, ov_a, or_a, err_a, busy_a;
  logic iv_b, ir_b, ov_b, or_b, err_b, busy_b;
  logic [6:0] s_a, s_b;
  logic [15:0] x16, y16, m16;
  logic iv_c, ir_c, ov_c, or_c, err_c, busy_c;
  logic [16:0] s_c;

  int n_vec = 0;
  int n_err = 0;

  montgomery_multiplier_iter #(.N(6), .BPC(1)) u_a (
    .clk(clk), .rst(rst), .in_valid(iv_a), .in_ready(ir_a), .X(x6), .Y(y6), .M(m6),
    .out_valid(ov_a), .out_ready(or_a), .S(s_a), .err(err_a), .busy(busy_a));

  montgomery_multiplier_iter #(.N(6), .BPC(2)) u_b (
    .clk(clk), .rst(rst), .in_valid(iv_b), .in_ready(ir_b), .X(x6), .Y(y6), .M(m6),
    .out_valid(ov_b), .out_ready(or_b), .S(s_b), .err(err_b), .busy(busy_b));

  montgomery_multiplier_iter #(.N(16), .BPC(4)) u_c (
    .clk(clk), .rst(rst), .in_valid(iv_c), .in_ready(ir_c), .X(x16), .Y(y16), .M(m16),
    .out_valid(ov_c), .out_ready(or_c), .S(s_c), .err(err_c), .busy(busy_c));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_reset_a(input string tag);
    check({tag, " in_ready"},  {63'd0, ir_a},   64'd1);
    check({tag, " out_valid"}, {63'd0, ov_a},   64'd0);
    check({tag, " S"},         {57'd0, s_a},    64'd0);
    check({tag, " err"},       {63'd0, err_a},  64'd0);
    check({tag, " busy"},      {63'd0, busy_a}, 64'd0);
  endtask

  // Runs one vector on a and b in parallel; called at posedge+1.
  task automatic run_pair(input vec_t v);
    logic [6:0] exp_s;
    int la, lb, exp_lat_a, exp_lat_b;
    exp_s     = FULL_RED ? v.s_on : v.s_off;
    exp_lat_a = v.e ? 1 : LAT_A;
    exp_lat_b = v.e ? 1 : LAT_B;
    la = 0;
    lb = 0;
    check("pair in_ready_a idle", {63'd0, ir_a}, 64'd1);
    x6 = v.x; y6 = v.y; m6 = v.m;
    iv_a = 1'b1; iv_b = 1'b1; or_a = 1'b0; or_b = 1'b0;
    @(posedge clk); #1;
    iv_a = 1'b0; iv_b = 1'b0;
    for (int i = 1; i <= 40 && (la == 0 || lb == 0); i++) begin
      if (i > 1) begin
        @(posedge clk); #1;
      end
      if (ov_a && la == 0) la = i;
      if (ov_b && lb == 0) lb = i;
    end
    check("pair latency_a", la, exp_lat_a);
    check("pair latency_b", lb, exp_lat_b);
    check("pair S_a", {57'd0, s_a}, {57'd0, exp_s});
    check("pair S_b", {57'd0, s_b}, {57'd0, exp_s});
    check("pair err_a", {63'd0, err_a}, {63'd0, v.e});
    check("pair err_b", {63'd0, err_b}, {63'd0, v.e});
    or_a = 1'b1; or_b = 1'b1;
    @(posedge clk); #1;
    or_a = 1'b0; or_b = 1'b0;
    check("pair out_valid_a drop", {63'd0, ov_a}, 64'd0);
    check("pair in_ready_a back",  {63'd0, ir_a}, 64'd1);
    check("pair out_valid_b drop", {63'd0, ov_b}, 64'd0);
  endtask

  vec_t tbl[9];

  initial begin
    int lat;
    tbl[0] = '{6'd60, 6'd60, 6'd61, 7'd41, 7'd102, 1'b0};
    tbl[1] = '{6'd5,  6'd7,  6'd13, 7'd4,  7'd4,   1'b0};
    tbl[2] = '{6'd3,  6'd4,  6'd12, 7'd0,  7'd0,   1'b1};
    tbl[3] = '{6'd5,  6'd7,  6'd13, 7'd4,  7'd4,   1'b0};
    tbl[4] = '{6'd0,  6'd33, 6'd61, 7'd0,  7'd0,   1'b0};
    tbl[5] = '{6'd1,  6'd1,  6'd13, 7'd12, 7'd12,  1'b0};
    tbl[6] = '{6'd62, 6'd62, 6'd63, 7'd1,  7'd64,  1'b0};
    tbl[7] = '{6'd2,  6'd2,  6'd3,  7'd1,  7'd1,   1'b0};
    tbl[8] = '{6'd9,  6'd9,  6'd0,  7'd0,  7'd0,   1'b1};

    rst = 1'b0;
    x6 = 6'd0; y6 = 6'd0; m6 = 6'd0;
    iv_a = 1'b0; iv_b = 1'b0; or_a = 1'b0; or_b = 1'b0;
    x16 = 16'd0; y16 = 16'd0; m16 = 16'd0; iv_c = 1'b0; or_c = 1'b0;
    #12;
    check_reset_a("reset");
    check("reset busy_c", {63'd0, busy_c}, 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Table vectors.
    for (int i = 0; i < 9; i++) run_pair(tbl[i]);

    // Result held while out_ready is low; input pulses ignored.
    x6 = 6'd5; y6 = 6'd7; m6 = 6'd13; iv_a = 1'b1;
    @(posedge clk); #1;
    iv_a = 1'b0;
    lat = 0;
    for (int i = 1; i <= 40 && lat == 0; i++) begin
      if (ov_a) lat = i;
      else begin
        @(posedge clk); #1;
      end
    end
    check("stall latency", lat, LAT_A);
    for (int i = 0; i < 10; i++) begin
      x6 = 6'd60; y6 = 6'd60; m6 = 6'd61;
      iv_a = i[0];
      @(posedge clk); #1;
      check("stall out_valid", {63'd0, ov_a}, 64'd1);
      check("stall S", {57'd0, s_a}, 64'd4);
      check("stall err", {63'd0, err_a}, 64'd0);
      check("stall in_ready", {63'd0, ir_a}, 64'd0);
    end
    iv_a = 1'b0;
    or_a = 1'b1;
    @(posedge clk); #1;
    or_a = 1'b0;
    check("stall release out_valid", {63'd0, ov_a}, 64'd0);
    check("stall release in_ready",  {63'd0, ir_a}, 64'd1);
    @(posedge clk); #1;
    check("stall no ghost op busy", {63'd0, busy_a}, 64'd0);

    // out_ready already high: transfer on the first DONE cycle.
    or_a = 1'b1;
    x6 = 6'd1; y6 = 6'd1; m6 = 6'd63; iv_a = 1'b1;
    @(posedge clk); #1;
    iv_a = 1'b0;
    lat = 0;
    for (int i = 1; i <= 40 && lat == 0; i++) begin
      if (ov_a) lat = i;
      else begin
        @(posedge clk); #1;
      end
    end
    check("early ready latency", lat, LAT_A);
    check("early ready S", {57'd0, s_a}, 64'd1);
    @(posedge clk); #1;
    check("early ready out_valid one cycle", {63'd0, ov_a}, 64'd0);
    check("early ready in_ready", {63'd0, ir_a}, 64'd1);
    or_a = 1'b0;

    // Reset dropped mid-RUN (count=3).
    x6 = 6'd60; y6 = 6'd60; m6 = 6'd61; iv_a = 1'b1;
    @(posedge clk); #1;
    iv_a = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("midrun busy", {63'd0, busy_a}, 64'd1);
    rst = 1'b0;
    #1;
    check_reset_a("midrun reset");
    #3;
    rst = 1'b1;
    run_pair(tbl[0]);

    // Random N=16 operations with handshake stalls.
    for (int op = 0; op < 300; op++) begin
      longint unsigned xl, yl, ml, sl, lim;
      int lc;
      ml = longint'(($urandom & 32'h0000_FFFF) | 32'd1);
      xl = longint'($urandom) % ml;
      yl = longint'($urandom) % ml;
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
      end
      check("rand in_ready", {63'd0, ir_c}, 64'd1);
      x16 = xl[15:0]; y16 = yl[15:0]; m16 = ml[15:0]; iv_c = 1'b1;
      @(posedge clk); #1;
      iv_c = 1'b0;
      x16 = 16'hFFFF; y16 = 16'hFFFF; m16 = 16'd2;
      lc = 0;
      for (int i = 1; i <= 50 && lc == 0; i++) begin
        if (ov_c) lc = i;
        else begin
          @(posedge clk); #1;
        end
      end
      check("rand latency", lc, LAT_C);
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
      end
      sl  = {47'd0, s_c};
      lim = FULL_RED ? ml : 2 * ml;
      check("rand congruence", (sl * 64'd65536) % ml, (xl * yl) % ml);
      check("rand range", {63'd0, (sl < lim)}, 64'd1);
      check("rand err", {63'd0, err_c}, 64'd0);
      or_c = 1'b1;
      @(posedge clk); #1;
      or_c = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
